// File: rtl/pong_frame_controller.sv
// pong_frame_controller
// Frame-level sequencer for Pong: owns the menu/play/game-over mode FSM and,
// once per frame tick, steps the shared datapath through move, clear and draw
// phases while supplying the one-hot phase strobes, plot enable and pixel index.
// Optional build macro: PONG_FAST_FRAME_EN -- when defined, the frame period is
// fixed at 32768 cycles (FRAME_CYCLES ignored) to shorten simulation.
module pong_frame_controller #(
  parameter int FRAME_CYCLES  = 833333,
  parameter int SCREEN_PIXELS = 19200,
  parameter int PAD_PIXELS    = 32,
  parameter int BALL_PIXELS   = 4,
  parameter int WIN_SCORE     = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        point_scored,
  input  logic [3:0]  left_score,
  input  logic [3:0]  right_score,
  output logic        menu,
  output logic        gameover,
  output logic        move_pads,
  output logic        move_ball,
  output logic        reset_delta,
  output logic        set_up_clear_screen,
  output logic        clear_screen,
  output logic        set_up_left_pad,
  output logic        draw_left_pad,
  output logic        set_up_right_pad,
  output logic        draw_right_pad,
  output logic        set_up_ball,
  output logic        draw_ball,
  output logic        plot,
  output logic [14:0] pix_count
);

`ifdef PONG_FAST_FRAME_EN
  localparam int FRAME_PERIOD = 32768;
`else
  localparam int FRAME_PERIOD = FRAME_CYCLES;
`endif

  localparam int CNT_W = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

  localparam logic [14:0] SCR_LAST  = 15'(SCREEN_PIXELS - 1);
  localparam logic [14:0] PAD_LAST  = 15'(PAD_PIXELS - 1);
  localparam logic [14:0] BALL_LAST = 15'(BALL_PIXELS - 1);
  localparam logic [3:0]  WIN4      = 4'(WIN_SCORE);

  typedef enum logic [3:0] {
    S_MENU        = 4'd0,
    S_SERVE       = 4'd1,
    S_WAIT_FRAME  = 4'd2,
    S_MOVE_PADS   = 4'd3,
    S_MOVE_BALL   = 4'd4,
    S_CHECK       = 4'd5,
    S_SETUP_CLEAR = 4'd6,
    S_CLEAR       = 4'd7,
    S_SETUP_LPAD  = 4'd8,
    S_DRAW_LPAD   = 4'd9,
    S_SETUP_RPAD  = 4'd10,
    S_DRAW_RPAD   = 4'd11,
    S_SETUP_BALL  = 4'd12,
    S_DRAW_BALL   = 4'd13,
    S_GAMEOVER    = 4'd14
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [14:0]       pix_nx;
  logic              enter_q;
  logic              enter_rise;
  logic [CNT_W-1:0]  frame_cnt;
  logic              frame_tick;
  logic              frame_pending;
  logic              point_q;
  logic              win;

  // Enter edge detector; enter_q resets high so a key held through reset is not a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_q    <= 1'b1;
      enter_rise <= 1'b0;
    end else begin
      enter_q    <= enter;
      enter_rise <= enter & ~enter_q;
    end
  end

  // Free-running frame counter; frame_tick is high for the cycle following the wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (frame_cnt == CNT_LAST);
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Remember one tick that arrives while the frame is still being processed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_pending <= 1'b0;
    end else if ((state == S_WAIT_FRAME) && (frame_tick || frame_pending)) begin
      frame_pending <= 1'b0;
    end else if (frame_tick && (state != S_WAIT_FRAME)) begin
      frame_pending <= 1'b1;
    end
  end

  // Capture the datapath's point flag while the ball moves, for use in CHECK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      point_q <= 1'b0;
    end else if (state == S_MOVE_BALL) begin
      point_q <= point_scored;
    end
  end

  assign win = (left_score >= WIN4) || (right_score >= WIN4);

  // Next-state and next pixel index
  always_comb begin
    state_nx = state;
    pix_nx   = pix_count;
    unique case (state)
      S_MENU:       if (enter_rise) state_nx = S_SERVE;
      S_SERVE:      state_nx = S_SETUP_CLEAR;
      S_WAIT_FRAME: if (frame_tick || frame_pending) state_nx = S_MOVE_PADS;
      S_MOVE_PADS:  state_nx = S_MOVE_BALL;
      S_MOVE_BALL:  state_nx = S_CHECK;
      S_CHECK: begin
        if (win) begin
          state_nx = S_GAMEOVER;
        end else if (point_q) begin
          state_nx = S_SERVE;
        end else begin
          state_nx = S_SETUP_CLEAR;
        end
      end
      S_SETUP_CLEAR: begin
        state_nx = S_CLEAR;
        pix_nx   = '0;
      end
      S_CLEAR: begin
        if (pix_count == SCR_LAST) begin
          state_nx = S_SETUP_LPAD;
          pix_nx   = '0;
        end else begin
          pix_nx = pix_count + 15'd1;
        end
      end
      S_SETUP_LPAD: begin
        state_nx = S_DRAW_LPAD;
        pix_nx   = '0;
      end
      S_DRAW_LPAD: begin
        if (pix_count == PAD_LAST) begin
          state_nx = S_SETUP_RPAD;
          pix_nx   = '0;
        end else begin
          pix_nx = pix_count + 15'd1;
        end
      end
      S_SETUP_RPAD: begin
        state_nx = S_DRAW_RPAD;
        pix_nx   = '0;
      end
      S_DRAW_RPAD: begin
        if (pix_count == PAD_LAST) begin
          state_nx = S_SETUP_BALL;
          pix_nx   = '0;
        end else begin
          pix_nx = pix_count + 15'd1;
        end
      end
      S_SETUP_BALL: begin
        state_nx = S_DRAW_BALL;
        pix_nx   = '0;
      end
      S_DRAW_BALL: begin
        if (pix_count == BALL_LAST) begin
          state_nx = S_WAIT_FRAME;
          pix_nx   = '0;
        end else begin
          pix_nx = pix_count + 15'd1;
        end
      end
      S_GAMEOVER:   if (enter_rise) state_nx = S_MENU;
      default: begin
        state_nx = S_MENU;
        pix_nx   = '0;
      end
    endcase
  end

  // Mode FSM with outputs registered from the next state, so they match the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_MENU;
      pix_count           <= '0;
      menu                <= 1'b1;
      gameover            <= 1'b0;
      reset_delta         <= 1'b0;
      move_pads           <= 1'b0;
      move_ball           <= 1'b0;
      set_up_clear_screen <= 1'b0;
      clear_screen        <= 1'b0;
      set_up_left_pad     <= 1'b0;
      draw_left_pad       <= 1'b0;
      set_up_right_pad    <= 1'b0;
      draw_right_pad      <= 1'b0;
      set_up_ball         <= 1'b0;
      draw_ball           <= 1'b0;
      plot                <= 1'b0;
    end else begin
      state               <= state_nx;
      pix_count           <= pix_nx;
      menu                <= (state_nx == S_MENU);
      gameover            <= (state_nx == S_GAMEOVER);
      reset_delta         <= (state_nx == S_SERVE);
      move_pads           <= (state_nx == S_MOVE_PADS);
      move_ball           <= (state_nx == S_MOVE_BALL);
      set_up_clear_screen <= (state_nx == S_SETUP_CLEAR);
      clear_screen        <= (state_nx == S_CLEAR);
      set_up_left_pad     <= (state_nx == S_SETUP_LPAD);
      draw_left_pad       <= (state_nx == S_DRAW_LPAD);
      set_up_right_pad    <= (state_nx == S_SETUP_RPAD);
      draw_right_pad      <= (state_nx == S_DRAW_RPAD);
      set_up_ball         <= (state_nx == S_SETUP_BALL);
      draw_ball           <= (state_nx == S_DRAW_BALL);
      plot                <= (state_nx == S_CLEAR) || (state_nx == S_DRAW_LPAD) ||
                             (state_nx == S_DRAW_RPAD) || (state_nx == S_DRAW_BALL);
    end
  end

endmodule

// File: tb/tb_pong_frame_controller.sv
// Bench for pong_frame_controller: a script-based reference model predicts the
// outputs of every cycle; directed scenarios plus randomized play follow.
module tb_pong_frame_controller;
  localparam int FC = 150;
  localparam int SP = 64;
  localparam int PP = 32;
  localparam int BP = 4;
  localparam int WS = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic        point_scored;
  logic [3:0]  left_score;
  logic [3:0]  right_score;
  logic        menu, gameover, move_pads, move_ball, reset_delta;
  logic        set_up_clear_screen, clear_screen, set_up_left_pad, draw_left_pad;
  logic        set_up_right_pad, draw_right_pad, set_up_ball, draw_ball, plot;
  logic [14:0] pix_count;

  always #5 clk = ~clk;

  pong_frame_controller #(
    .FRAME_CYCLES(FC), .SCREEN_PIXELS(SP), .PAD_PIXELS(PP),
    .BALL_PIXELS(BP), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .point_scored(point_scored),
    .left_score(left_score), .right_score(right_score),
    .menu(menu), .gameover(gameover), .move_pads(move_pads), .move_ball(move_ball),
    .reset_delta(reset_delta), .set_up_clear_screen(set_up_clear_screen),
    .clear_screen(clear_screen), .set_up_left_pad(set_up_left_pad),
    .draw_left_pad(draw_left_pad), .set_up_right_pad(set_up_right_pad),
    .draw_right_pad(draw_right_pad), .set_up_ball(set_up_ball),
    .draw_ball(draw_ball), .plot(plot), .pix_count(pix_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model phase tags (one per observable step of the game script)
  localparam int M_MENU = 0, M_SERVE = 1, M_WAIT = 2, M_MPADS = 3, M_MBALL = 4,
                 M_CHECK = 5, M_SCLR = 6, M_CLR = 7, M_SLP = 8, M_DLP = 9,
                 M_SRP = 10, M_DRP = 11, M_SB = 12, M_DB = 13, M_OVER = 14;

  int cur_code;
  int cur_pix;
  int q_code[$];
  int q_pix[$];
  bit pend;
  bit enter_prev;
  bit rise_q;
  bit pt;
  int k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired, got timeout expected event", name);
  endtask

  function automatic logic [13:0] exp_vec(input int c);
    logic [13:0] v;
    v = '0;
    v[13] = (c == M_MENU);
    v[12] = (c == M_OVER);
    v[11] = (c == M_SERVE);
    v[10] = (c == M_MPADS);
    v[9]  = (c == M_MBALL);
    v[8]  = (c == M_SCLR);
    v[7]  = (c == M_CLR);
    v[6]  = (c == M_SLP);
    v[5]  = (c == M_DLP);
    v[4]  = (c == M_SRP);
    v[3]  = (c == M_DRP);
    v[2]  = (c == M_SB);
    v[1]  = (c == M_DB);
    v[0]  = (c == M_CLR) || (c == M_DLP) || (c == M_DRP) || (c == M_DB);
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {menu, gameover, reset_delta, move_pads, move_ball, set_up_clear_screen,
            clear_screen, set_up_left_pad, draw_left_pad, set_up_right_pad,
            draw_right_pad, set_up_ball, draw_ball, plot};
  endfunction

  // One frame of drawing: setup + N pixels for screen, left pad, right pad, ball
  task automatic push_draw();
    q_code.push_back(M_SCLR); q_pix.push_back(0);
    for (int i = 0; i < SP; i++) begin q_code.push_back(M_CLR); q_pix.push_back(i); end
    q_code.push_back(M_SLP); q_pix.push_back(0);
    for (int i = 0; i < PP; i++) begin q_code.push_back(M_DLP); q_pix.push_back(i); end
    q_code.push_back(M_SRP); q_pix.push_back(0);
    for (int i = 0; i < PP; i++) begin q_code.push_back(M_DRP); q_pix.push_back(i); end
    q_code.push_back(M_SB); q_pix.push_back(0);
    for (int i = 0; i < BP; i++) begin q_code.push_back(M_DB); q_pix.push_back(i); end
  endtask

  task automatic pop_or_wait();
    if (q_code.size() > 0) begin
      cur_code = q_code.pop_front();
      cur_pix  = q_pix.pop_front();
    end else begin
      cur_code = M_WAIT;
      cur_pix  = 0;
    end
  endtask

  task automatic model_reset();
    cur_code = M_MENU; cur_pix = 0;
    q_code.delete(); q_pix.delete();
    pend = 0; enter_prev = 1; rise_q = 0; pt = 0; k = 0;
  endtask

  // Advance the model across one rising edge using the inputs the DUT sampled
  task automatic model_step();
    bit tick_now;
    bit rise_now;
    int old;
    tick_now = (k > 0) && (k % FC == 0);
    rise_now = rise_q;
    old = cur_code;
    case (old)
      M_MENU:  if (rise_now) begin cur_code = M_SERVE; cur_pix = 0; end
      M_OVER:  if (rise_now) begin cur_code = M_MENU; cur_pix = 0; end
      M_SERVE: begin push_draw(); pop_or_wait(); end
      M_WAIT:  if (tick_now || pend) begin cur_code = M_MPADS; cur_pix = 0; end
      M_MPADS: cur_code = M_MBALL;
      M_MBALL: begin pt = point_scored; cur_code = M_CHECK; end
      M_CHECK: begin
        if (left_score >= 4'(WS) || right_score >= 4'(WS)) cur_code = M_OVER;
        else if (pt) cur_code = M_SERVE;
        else begin push_draw(); pop_or_wait(); end
      end
      default: pop_or_wait();
    endcase
    if (old == M_WAIT && (tick_now || pend)) pend = 0;
    else if (tick_now && old != M_WAIT) pend = 1;
    rise_q = enter & ~enter_prev;
    enter_prev = enter;
    k++;
  endtask

  task automatic compare();
    check("outputs", 32'(dut_vec()), 32'(exp_vec(cur_code)));
    check("pix_count", 32'(pix_count), 32'(cur_pix));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  int plot_cnt, len, wait_len, max_c, max_l, max_r, max_b, guard;
  bit seen_wait;

  initial begin
    reset = 1'b0; enter = 1'b1; point_scored = 1'b0;
    left_score = 4'd3; right_score = 4'd4;
    model_reset();
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    compare();
    check("reset_menu", 32'(menu), 32'd1);
    check("reset_pix", 32'(pix_count), 32'd0);
    reset = 1'b0;

    // enter held through reset must not start a game; ticks pile up in MENU
    repeat (400) cycle();
    check("menu_held", 32'(menu), 32'd1);
    check("no_serve", 32'(reset_delta), 32'd0);

    // enter rise: SERVE two edges later, then SETUP_CLEAR
    enter = 1'b0; cycle();
    enter = 1'b1; cycle();
    check("serve_not_yet", 32'(menu), 32'd1);
    cycle();
    check("serve_pulse", 32'(reset_delta), 32'd1);
    cycle();
    check("setup_clear", 32'(set_up_clear_screen), 32'd1);
    check("serve_one_cycle", 32'(reset_delta), 32'd0);

    // one full frame: plot count, pixel ranges, draw length, pending wait
    plot_cnt = 0; len = 0; wait_len = 0; seen_wait = 0;
    max_c = 0; max_l = 0; max_r = 0; max_b = 0; guard = 0;
    while (!move_pads && guard < 1000) begin
      if (plot) plot_cnt++;
      if (clear_screen && pix_count > max_c) max_c = pix_count;
      if (draw_left_pad && pix_count > max_l) max_l = pix_count;
      if (draw_right_pad && pix_count > max_r) max_r = pix_count;
      if (draw_ball && pix_count > max_b) max_b = pix_count;
      if (dut_vec() == 14'd0) begin seen_wait = 1; wait_len++; end
      else if (!seen_wait) len++;
      cycle();
      guard++;
    end
    if (guard >= 1000) timeout("frame_end");
    check("plot_cycles", 32'(plot_cnt), 32'(SP + 2*PP + BP));
    check("draw_len", 32'(len), 32'(4 + SP + 2*PP + BP));
    check("pix_clear_max", 32'(max_c), 32'(SP - 1));
    check("pix_lpad_max", 32'(max_l), 32'(PP - 1));
    check("pix_rpad_max", 32'(max_r), 32'(PP - 1));
    check("pix_ball_max", 32'(max_b), 32'(BP - 1));
    check("pending_wait", 32'(wait_len), 32'd1);

    // point scored at 3/4: CHECK then SERVE then SETUP_CLEAR
    point_scored = 1'b1;
    guard = 0;
    while (!move_ball && guard < 1000) begin cycle(); guard++; end
    if (guard >= 1000) timeout("move_ball_wait");
    cycle();
    check("check_quiet", 32'(dut_vec()), 32'd0);
    cycle();
    check("point_serve", 32'(reset_delta), 32'd1);
    cycle();
    check("point_setup_clear", 32'(set_up_clear_screen), 32'd1);

    // winning score with point: GAMEOVER, no reset_delta
    left_score = 4'd9;
    guard = 0;
    while (!move_ball && guard < 1000) begin cycle(); guard++; end
    if (guard >= 1000) timeout("move_ball_wait2");
    cycle();
    cycle();
    check("gameover", 32'(gameover), 32'd1);
    check("gameover_no_serve", 32'(reset_delta), 32'd0);
    enter = 1'b0; cycle();
    enter = 1'b1; cycle();
    cycle();
    check("back_to_menu", 32'(menu), 32'd1);
    point_scored = 1'b0; left_score = 4'd0;

    // randomized play
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 49) == 0) enter = ~enter;
      point_scored = ($urandom_range(0, 3) == 0);
      left_score  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      right_score = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cycle();
    end

    // asynchronous reset in the middle of the right-paddle draw
    left_score = 4'd0; right_score = 4'd0; point_scored = 1'b0;
    guard = 0;
    while (!(draw_right_pad && pix_count > 5) && guard < 3000) begin
      if (menu || gameover) enter = ~enter;
      cycle();
      guard++;
    end
    if (guard >= 3000) timeout("draw_rpad_wait");
    #2 reset = 1'b1;
    #1;
    check("async_plot", 32'(plot), 32'd0);
    check("async_drp", 32'(draw_right_pad), 32'd0);
    check("async_menu", 32'(menu), 32'd1);
    check("async_pix", 32'(pix_count), 32'd0);
    model_reset();
    @(negedge clk);
    compare();
    reset = 1'b0;
    enter = 1'b1;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
